i2c_scl_master_generator: RTL and testbench

- Parametrised successor to the fixed-duty I2C clock divider.
- Generates the I2C master SCL as an open-drain enable, with per-mode asymmetric low/high phase lengths and period-boundary mode switching.
- Supports clock-stretching detection through SCL readback.
- Emits phase strobes (fall, change point, rise, sample point) that drive the byte/bit engine of the I2C master.

---
 rtl/i2c_scl_master_generator_pkg.sv | 33 +++
 rtl/i2c_scl_master_generator_bit_synchronizer.sv | 29 ++
 rtl/i2c_scl_master_generator.sv | 201 ++++++++++++++++++++
 tb/tb_i2c_scl_master_generator.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_scl_master_generator_pkg.sv
// i2c_pkg: speed-mode codes, SCL generator state encoding, bus frequencies and phase-length helpers.
package i2c_pkg;

    typedef enum logic [1:0] {
        SM  = 2'd0,
        FM  = 2'd1,
        FMP = 2'd2,
        HS  = 2'd3
    } speed_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOW       = 2'd1,
        HIGH_WAIT = 2'd2,
        HIGH      = 2'd3
    } state_e;

    localparam int F_SM  = 100_000;
    localparam int F_FM  = 400_000;
    localparam int F_FMP = 1_000_000;
    localparam int F_HS  = 3_400_000;

    // Codes with bit 2 set are not defined and fall back to Fast mode.
    function automatic speed_e decode_speed(input logic [2:0] code);
        return code[2] ? FM : speed_e'(code[1:0]);
    endfunction

    // Standard mode is symmetric; the faster modes use a 2:1 low/high split.
    function automatic int low_cycles(input int sys_clock, input int f, input logic half);
        return half ? (sys_clock / f) / 2 : (2 * (sys_clock / f)) / 3;
    endfunction

endpackage

// File: rtl/i2c_scl_master_generator_bit_synchronizer.sv
// i2c_bit_synchronizer: multi-stage flip-flop synchroniser for the SCL pad readback, idling high.
module i2c_bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic Clk_In,
    input  logic Reset_N_In,
    input  logic D_In,
    output logic Q_Out
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    if (STAGES < 2) begin : g_stage_err
        $error("i2c_bit_synchronizer: STAGES must be at least 2");
    end

    // Shift the pad value one stage deeper each cycle.
    always_comb sync_d = {sync_q[STAGES-2:0], D_In};

    // Chain resets to 1 so a released bus reads high straight out of reset.
    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) sync_q <= '1;
        else             sync_q <= sync_d;
    end

    assign Q_Out = sync_q[STAGES-1];

endmodule

// File: rtl/i2c_scl_master_generator.sv
// i2c_scl_master_generator: I2C master SCL generator with per-mode low/high phases, stretch detection
// and phase strobes. Optional stretch timeout is enabled by defining I2C_SCL_STRETCH_TIMEOUT_EN.
module i2c_scl_master_generator
    import i2c_pkg::*;
#(
    parameter int SYS_CLOCK      = 100_000_000,
    parameter int CNT_W          = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic       Clk_In,
    input  logic       Reset_N_In,
    input  logic       Enable_In,
    input  logic [2:0] Speed_Mode_In,
    input  logic       Scl_In,
    output logic       Scl_Oe_Out,
    output logic       Scl_Fall_Strobe_Out,
    output logic       Change_Strobe_Out,
    output logic       Scl_Rise_Strobe_Out,
    output logic       Sample_Strobe_Out,
    output logic       Busy_Out,
    output logic       Stretch_Out,
    output logic       Timeout_Out
);

    localparam int LOW_SM   = low_cycles(SYS_CLOCK, F_SM, 1'b1);
    localparam int LOW_FM   = low_cycles(SYS_CLOCK, F_FM, 1'b0);
    localparam int LOW_FMP  = low_cycles(SYS_CLOCK, F_FMP, 1'b0);
    localparam int LOW_HS   = low_cycles(SYS_CLOCK, F_HS, 1'b0);
    localparam int HIGH_SM  = SYS_CLOCK / F_SM - LOW_SM;
    localparam int HIGH_FM  = SYS_CLOCK / F_FM - LOW_FM;
    localparam int HIGH_FMP = SYS_CLOCK / F_FMP - LOW_FMP;
    localparam int HIGH_HS  = SYS_CLOCK / F_HS - LOW_HS;
    localparam int MAX_CNT  = (1 << CNT_W) - 1;
    // The high counter restarts at the number of cycles already spent released
    // in a non-stretched period: synchroniser depth plus the registered state change.
    localparam int RISE_LOAD = SYNC_STAGES + 1;

    if (LOW_SM > MAX_CNT || HIGH_SM > MAX_CNT || LOW_FM > MAX_CNT || HIGH_FM > MAX_CNT ||
        LOW_FMP > MAX_CNT || HIGH_FMP > MAX_CNT || LOW_HS > MAX_CNT || HIGH_HS > MAX_CNT) begin : g_cnt_err
        $error("i2c_scl_master_generator: phase count exceeds CNT_W range");
    end
    if (HIGH_SM < SYNC_STAGES + 3 || HIGH_FM < SYNC_STAGES + 3 ||
        HIGH_FMP < SYNC_STAGES + 3 || HIGH_HS < SYNC_STAGES + 3) begin : g_high_err
        $error("i2c_scl_master_generator: high phase too short for the SCL synchroniser");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_tmo_err
        $error("i2c_scl_master_generator: TIMEOUT_CYCLES must be at least 2");
    end

    function automatic logic [CNT_W-1:0] low_of(input speed_e m);
        return (m == SM)  ? CNT_W'(LOW_SM)  :
               (m == FMP) ? CNT_W'(LOW_FMP) :
               (m == HS)  ? CNT_W'(LOW_HS)  : CNT_W'(LOW_FM);
    endfunction

    function automatic logic [CNT_W-1:0] high_of(input speed_e m);
        return (m == SM)  ? CNT_W'(HIGH_SM)  :
               (m == FMP) ? CNT_W'(HIGH_FMP) :
               (m == HS)  ? CNT_W'(HIGH_HS)  : CNT_W'(HIGH_FM);
    endfunction

    logic scl_sync;

    i2c_bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
        .Clk_In     (Clk_In),
        .Reset_N_In (Reset_N_In),
        .D_In       (Scl_In),
        .Q_Out      (scl_sync)
    );

    state_e           state_q, state_d;
    speed_e           mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             oe_q, oe_d;
    logic             fall_q, fall_d;
    logic             chg_q, chg_d;
    logic             rise_q, rise_d;
    logic             smp_q, smp_d;
    logic             busy_q, busy_d;
    logic             str_q, str_d;
`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tmo_q, tmo_d;
`endif

    // Next-state, counter and strobe computation; strobes follow the next state so they register in phase.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        oe_d    = oe_q;
        fall_d  = 1'b0;
        rise_d  = 1'b0;
`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
        tmo_d   = tmo_q;
        tcnt_d  = (state_q == HIGH_WAIT) ? tcnt_q + TW'(1) : '0;
`endif
        case (state_q)
            IDLE: begin
                if (Enable_In) begin
                    state_d = LOW;
                    mode_d  = decode_speed(Speed_Mode_In);
                    cnt_d   = '0;
                    oe_d    = 1'b1;
                    fall_d  = 1'b1;
`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
                    tmo_d   = 1'b0;
`endif
                end
            end
            LOW: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == low_of(mode_q) - CNT_W'(1)) begin
                    state_d = HIGH_WAIT;
                    cnt_d   = '0;
                    oe_d    = 1'b0;
                end
            end
            HIGH_WAIT: begin
                if (scl_sync) begin
                    state_d = HIGH;
                    cnt_d   = CNT_W'(RISE_LOAD);
                    rise_d  = 1'b1;
                end
`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
                else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                    tmo_d   = 1'b1;
                end
`endif
            end
            HIGH: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == high_of(mode_q) - CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = Enable_In ? LOW : IDLE;
                    if (Enable_In) begin
                        mode_d = decode_speed(Speed_Mode_In);
                        oe_d   = 1'b1;
                        fall_d = 1'b1;
                    end
                end
            end
        endcase
        chg_d  = (state_d == LOW) && (cnt_d == (low_of(mode_d) >> 1));
        smp_d  = (state_d == HIGH) && (cnt_d == (high_of(mode_d) >> 1));
        busy_d = (state_d != IDLE);
        str_d  = (state_d == HIGH_WAIT);
    end

    // State and registered outputs; reset releases SCL and clears every strobe at once.
    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state_q <= IDLE;
            mode_q  <= FM;
            cnt_q   <= '0;
            oe_q    <= 1'b0;
            fall_q  <= 1'b0;
            chg_q   <= 1'b0;
            rise_q  <= 1'b0;
            smp_q   <= 1'b0;
            busy_q  <= 1'b0;
            str_q   <= 1'b0;
`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
            tcnt_q  <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            oe_q    <= oe_d;
            fall_q  <= fall_d;
            chg_q   <= chg_d;
            rise_q  <= rise_d;
            smp_q   <= smp_d;
            busy_q  <= busy_d;
            str_q   <= str_d;
`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
            tcnt_q  <= tcnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign Scl_Oe_Out          = oe_q;
    assign Scl_Fall_Strobe_Out = fall_q;
    assign Change_Strobe_Out   = chg_q;
    assign Scl_Rise_Strobe_Out = rise_q;
    assign Sample_Strobe_Out   = smp_q;
    assign Busy_Out            = busy_q;
    assign Stretch_Out         = str_q;
`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
    assign Timeout_Out         = tmo_q;
`else
    assign Timeout_Out         = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_scl_master_generator.sv
// tb_i2c_scl_master_generator: directed self-checking bench for the I2C SCL master generator (100 MHz).
module tb_i2c_scl_master_generator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [2:0] mode = 3'b000;
    logic       hold = 1'b0;
    logic       scl_in;
    logic       oe, fall, chg, rise, smp, busy, str, tmo;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;

    always #5 clk = ~clk;

    // Open-drain loopback: the pad is low while we pull it or while a slave stretches it.
    assign scl_in = ~oe & ~hold;

    i2c_scl_master_generator #(.TIMEOUT_CYCLES(1000)) dut (
        .Clk_In              (clk),
        .Reset_N_In          (rst_n),
        .Enable_In           (en),
        .Speed_Mode_In       (mode),
        .Scl_In              (scl_in),
        .Scl_Oe_Out          (oe),
        .Scl_Fall_Strobe_Out (fall),
        .Change_Strobe_Out   (chg),
        .Scl_Rise_Strobe_Out (rise),
        .Sample_Strobe_Out   (smp),
        .Busy_Out            (busy),
        .Stretch_Out         (str),
        .Timeout_Out         (tmo)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s at cycle %0d: observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int k);
        while (cyc < k) tick();
    endtask

    initial begin
        int nf, nc, nr, ns, pf, pc, pr, ps, multi, bad;
        repeat (2) @(posedge clk);
        #1;
        chk1("reset_outputs", |{oe, fall, chg, rise, smp, busy, str, tmo}, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        chk1("idle_oe", oe, 1'b0);
        chk1("idle_busy", busy, 1'b0);

        // Standard mode, 500/500.
        mode = 3'b000;
        en = 1'b1;
        cyc = -1;
        tick();
        chk1("sm_fall0", fall, 1'b1);
        chk1("sm_oe0", oe, 1'b1);
        chk1("sm_busy0", busy, 1'b1);
        step_to(249); chk1("sm_chg249", chg, 1'b0);
        step_to(250); chk1("sm_chg250", chg, 1'b1);
        step_to(499); chk1("sm_oe499", oe, 1'b1);
        step_to(500); chk1("sm_oe500", oe, 1'b0);
        chk1("sm_str500", str, 1'b1);
        step_to(502); chk1("sm_rise502", rise, 1'b0);
        step_to(503); chk1("sm_rise503", rise, 1'b1);
        chk1("sm_str503", str, 1'b0);
        step_to(750); chk1("sm_smp750", smp, 1'b1);
        step_to(999); chk1("sm_fall999", fall, 1'b0);
        step_to(1000); chk1("sm_fall1000", fall, 1'b1);
        chk1("sm_oe1000", oe, 1'b1);

        // Switch to Hs mid-low: this Sm period must finish untouched.
        step_to(1010); mode = 3'b011;
        step_to(1250); chk1("sw_chg1250", chg, 1'b1);
        step_to(1499); chk1("sw_oe1499", oe, 1'b1);
        step_to(1500); chk1("sw_oe1500", oe, 1'b0);
        step_to(1750); chk1("sw_smp1750", smp, 1'b1);
        step_to(2000); chk1("sw_fall2000", fall, 1'b1);
        step_to(2009); chk1("hs_chg", chg, 1'b1);
        step_to(2018); chk1("hs_oe_lowend", oe, 1'b1);
        step_to(2019); chk1("hs_oe_release", oe, 1'b0);
        step_to(2022); chk1("hs_rise", rise, 1'b1);
        step_to(2024); chk1("hs_smp", smp, 1'b1);
        mode = 3'b101;
        step_to(2028); chk1("hs_fall_early", fall, 1'b0);
        step_to(2029); chk1("hs_fall_period29", fall, 1'b1);
        step_to(2194); chk1("ill_oe_lowend", oe, 1'b1);
        step_to(2195); chk1("ill_oe_release", oe, 1'b0);
        mode = 3'b001;
        step_to(2279); chk1("ill_fall_period250", fall, 1'b1);

        // One full Fm period: one of each strobe, in order, never two at once.
        nf = 0; nc = 0; nr = 0; ns = 0; pf = -1; pc = -1; pr = -1; ps = -1; multi = 0;
        for (int i = 0; i < 250; i++) begin
            if (fall) begin nf++; pf = i; end
            if (chg)  begin nc++; pc = i; end
            if (rise) begin nr++; pr = i; end
            if (smp)  begin ns++; ps = i; end
            if (int'(fall) + int'(chg) + int'(rise) + int'(smp) > 1) multi++;
            tick();
        end
        chkn("fm_fall_count", nf, 1);
        chkn("fm_chg_count", nc, 1);
        chkn("fm_rise_count", nr, 1);
        chkn("fm_smp_count", ns, 1);
        chkn("fm_fall_pos", pf, 0);
        chkn("fm_chg_pos", pc, 83);
        chkn("fm_rise_pos", pr, 169);
        chkn("fm_smp_pos", ps, 208);
        chkn("fm_strobe_overlap", multi, 0);
        chk1("fm_next_fall", fall, 1'b1);

        // Slave holds SCL low for 300 cycles after release.
        step_to(2694); hold = 1'b1;
        step_to(2695); chk1("st_str_start", str, 1'b1);
        chk1("st_oe_released", oe, 1'b0);
        step_to(2995); hold = 1'b0;
        chk1("st_str_held", str, 1'b1);
        chk1("st_no_timeout", tmo, 1'b0);
        step_to(2997); chk1("st_str_last", str, 1'b1);
        chk1("st_rise_wait", rise, 1'b0);
        step_to(2998); chk1("st_rise", rise, 1'b1);
        chk1("st_str_end", str, 1'b0);
        step_to(3037); chk1("st_smp", smp, 1'b1);
        step_to(3078); chk1("st_fall_early", fall, 1'b0);
        step_to(3079); chk1("st_fall_high84", fall, 1'b1);

        // Drop enable at low count 10: period completes, then idle.
        step_to(3089); en = 1'b0;
        step_to(3245); chk1("dis_oe_release", oe, 1'b0);
        step_to(3248); chk1("dis_rise", rise, 1'b1);
        step_to(3328); chk1("dis_busy_high", busy, 1'b1);
        step_to(3329); chk1("dis_busy_idle", busy, 1'b0);
        chk1("dis_oe_idle", oe, 1'b0);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            if (fall || oe) bad++;
            tick();
        end
        chkn("dis_no_restart", bad, 0);

        // Asynchronous reset mid-HIGH while a sample strobe is active.
        en = 1'b1;
        step_to(3630); chk1("rh_fall", fall, 1'b1);
        step_to(3838); chk1("rh_smp", smp, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk1("rh_async_clear", |{oe, fall, chg, rise, smp, busy, str, tmo}, 1'b0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset mid-LOW releases SCL immediately.
        en = 1'b1;
        cyc = -1;
        tick();
        chk1("rl_fall", fall, 1'b1);
        step_to(5);
        chk1("rl_oe_low", oe, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk1("rl_async_release", oe | busy, 1'b0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
        // SCL stuck low: give up after 1000 cycles, then clear on the next start.
        hold = 1'b1;
        mode = 3'b001;
        en = 1'b1;
        cyc = -1;
        tick();
        chk1("to_fall", fall, 1'b1);
        step_to(1165); chk1("to_str_last", str, 1'b1);
        chk1("to_not_yet", tmo, 1'b0);
        step_to(1166); chk1("to_set", tmo, 1'b1);
        chk1("to_busy_drop", busy, 1'b0);
        chk1("to_oe_released", oe, 1'b0);
        step_to(1167); chk1("to_restart_fall", fall, 1'b1);
        chk1("to_clear", tmo, 1'b0);
        hold = 1'b0;
        en = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
